generador_onda_cuadrada: RTL

Numerically controlled square-wave generator placed directly downstream of the frequency selector. Consumes the selected frequency word `f` (Hz) and produces a 50 % duty square wave on `onda` using a phase accumulator. Frequency changes and stops take effect only at a period boundary, so the output never shows runt pulses. Also produces a one-cycle strobe per rising edge for downstream counters and the display path.

---
 rtl/onda_pkg.sv | 27 ++
 rtl/acumulador_fase.sv | 48 ++++
 rtl/generador_onda_cuadrada.sv | 128 ++++++++++++
 3 files changed

// File: rtl/onda_pkg.sv
// Shared definitions for the square-wave generator: FSM states, the
// step-per-Hz helper and the Nyquist saturation limit for the phase step.
package onda_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } estado_t;

  localparam int unsigned ACC_W_DEF    = 32;
  localparam logic [63:0] STEP_SAT_DEF = (64'd1 << (ACC_W_DEF - 1)) - 64'd1;

  // round(2^acc_w / clk_hz): accumulator step that advances the phase by 1 Hz
  function automatic logic [63:0] calc_k(input logic [63:0] clk_hz,
                                         input int unsigned acc_w);
    logic [63:0] full;
    full = 64'd1 << acc_w;
    return (full + (clk_hz >> 1)) / clk_hz;
  endfunction

  // Largest step that still gives one high and one low sample per period
  function automatic logic [63:0] step_sat(input int unsigned acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/acumulador_fase.sv
// Phase accumulator: acc register, adder, carry-out wrap flag and the
// square-wave / rising-edge outputs derived from the accumulator MSB.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force acc to 0 on the next edge (idle / stop)
//   step      - phase increment applied every edge when clr is low
//   onda      - square wave (acc MSB, straight from the register)
//   flanco    - registered one-cycle pulse in the cycle onda first reads 1
//   wrap      - combinational carry-out of acc + step for the current cycle
module acumulador_fase
  import onda_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [ACC_W-1:0] step,
  output logic             onda,
  output logic             flanco,
  output logic             wrap
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]   suma;

  // Adder with one extra bit so the carry-out marks the period boundary
  always_comb begin
    suma    = {1'b0, acc} + {1'b0, step};
    acc_nxt = clr ? '0 : suma[ACC_W-1:0];
  end

  assign wrap = suma[ACC_W];
  assign onda = acc[ACC_W-1];

  // flanco is computed from the next MSB so it lines up with onda
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      flanco <= 1'b0;
    end else begin
      acc    <= acc_nxt;
      flanco <= acc_nxt[ACC_W-1] & ~acc[ACC_W-1];
    end
  end

endmodule

// File: rtl/generador_onda_cuadrada.sv
// Numerically controlled 50 % square-wave generator. Frequency changes and
// stops only take effect at a phase wrap, so no runt pulses are produced.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   ENf      - run request (registered before use)
//   f        - requested frequency in Hz, 0 = silence (registered before use)
//   onda     - square wave output
//   flanco   - one-cycle pulse per rising edge of onda
//   activo   - high while the generator is in RUN or DRAIN
module generador_onda_cuadrada
  import onda_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned F_W   = 11,
  parameter int unsigned K     = 43
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ENf,
  input  logic [F_W-1:0] f,
  output logic           onda,
  output logic           flanco,
  output logic           activo
);

  localparam int unsigned      PROD_W = ACC_W + F_W;
  localparam logic [PROD_W-1:0] SAT_P = PROD_W'(step_sat(ACC_W));

  estado_t          estado, estado_nxt;
  logic             en_r;
  logic [F_W-1:0]   f_r;
  logic [F_W-1:0]   f_act, f_act_nxt;
  logic             activo_nxt;
  logic             clr;
  logic             wrap;
  logic             run_ok;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0] step;

  // Input registers: every decision below uses these copies
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r <= 1'b0;
      f_r  <= '0;
    end else begin
      en_r <= ENf;
      f_r  <= f;
    end
  end

  // Step = f_act * K, clamped at the Nyquist limit
  always_comb begin
    prod = PROD_W'(f_act) * PROD_W'(K);
    step = (prod > SAT_P) ? ACC_W'(SAT_P) : ACC_W'(prod);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= IDLE;
      f_act  <= '0;
      activo <= 1'b0;
    end else begin
      estado <= estado_nxt;
      f_act  <= f_act_nxt;
      activo <= activo_nxt;
    end
  end

  // Next-state logic; f_act only reloads at a wrap so periods are never split
  always_comb begin
    estado_nxt = estado;
    f_act_nxt  = f_act;
    clr        = 1'b0;
    run_ok     = en_r && (f_r != '0);

    case (estado)
      IDLE: begin
        clr = 1'b1;
        if (run_ok) begin
          estado_nxt = RUN;
          f_act_nxt  = f_r;
        end
      end
      RUN: begin
        if (wrap) begin
          if (run_ok) begin
            f_act_nxt = f_r;
          end else begin
            estado_nxt = IDLE;
            clr        = 1'b1;
          end
        end else if (!run_ok) begin
          estado_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Re-enable wins over the wrap so a restored request causes no gap
        if (run_ok) begin
          estado_nxt = RUN;
          if (wrap) f_act_nxt = f_r;
        end else if (wrap) begin
          estado_nxt = IDLE;
          clr        = 1'b1;
        end
      end
      default: begin
        estado_nxt = IDLE;
        clr        = 1'b1;
      end
    endcase

    activo_nxt = (estado_nxt != IDLE);
  end

  acumulador_fase #(
    .ACC_W (ACC_W)
  ) u_acumulador_fase (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .step   (step),
    .onda   (onda),
    .flanco (flanco),
    .wrap   (wrap)
  );

endmodule
